// File: rtl/pulsador_debounce.sv
// Per-channel pushbutton debouncer: 2-flop synchroniser, 4-state FSM with
// its own stability counter, registered one-clock press pulse and debounced level.
module pulsador_debounce #(
  parameter int PUL_WIDTH  = 3,
  parameter int DEB_CYCLES = 500000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PUL_WIDTH-1:0] i_pulsador,
  output logic [PUL_WIDTH-1:0] o_pulsador,
  output logic [PUL_WIDTH-1:0] o_level
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } deb_state_t;

  logic [PUL_WIDTH-1:0] s1_reg;
  logic [PUL_WIDTH-1:0] s2_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= i_pulsador;
      s2_reg <= s1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PUL_WIDTH; gi++) begin : g_chan
      deb_state_t    state_reg, state_next;
      logic [CW-1:0] cnt_reg, cnt_next;
      logic          pulse_reg, pulse_next;
      logic          level_reg, level_next;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          pulse_reg <= 1'b0;
          level_reg <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          pulse_reg <= pulse_next;
          level_reg <= level_next;
        end
      end

      // The counter only advances while the synchronised input stays on the
      // candidate level; it is reset whenever a new level is accepted or rejected.
      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pulse_next = 1'b0;
        level_next = level_reg;
        case (state_reg)
          IDLE: begin
            if (s2_reg[gi]) begin
              state_next = WAIT_HIGH;
              cnt_next   = CNT_ONE;
            end else begin
              cnt_next = '0;
            end
          end
          WAIT_HIGH: begin
            if (!s2_reg[gi]) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
              state_next = HIGH;
              cnt_next   = '0;
              level_next = 1'b1;
              pulse_next = 1'b1;
            end else begin
              cnt_next = cnt_reg + CNT_ONE;
            end
          end
          HIGH: begin
            if (!s2_reg[gi]) begin
              state_next = WAIT_LOW;
              cnt_next   = CNT_ONE;
            end else begin
              cnt_next = '0;
            end
          end
          WAIT_LOW: begin
            if (s2_reg[gi]) begin
              state_next = HIGH;
              cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
              state_next = IDLE;
              cnt_next   = '0;
              level_next = 1'b0;
            end else begin
              cnt_next = cnt_reg + CNT_ONE;
            end
          end
          default: begin
            state_next = IDLE;
            cnt_next   = '0;
            level_next = 1'b0;
          end
        endcase
      end

      assign o_pulsador[gi] = pulse_reg;
      assign o_level[gi]    = level_reg;
    end
  endgenerate

endmodule

// File: tb/tb_pulsador_debounce.sv
// Directed bench for pulsador_debounce with DEB_CYCLES=4, PUL_WIDTH=3; expected
// waveforms are hand-derived (input applied after edge k => pulse after edge k+6).
module tb_pulsador_debounce;

  localparam int PW  = 3;
  localparam int DEB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [PW-1:0] i_pulsador = '0;
  logic [PW-1:0] o_pulsador;
  logic [PW-1:0] o_level;

  int n_cmp = 0;
  int n_bad = 0;

  pulsador_debounce #(.PUL_WIDTH(PW), .DEB_CYCLES(DEB)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_pulsador (i_pulsador),
    .o_pulsador (o_pulsador),
    .o_level    (o_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs n edges; cycle i (1-based) expects the pulse mask only at pulse_at
  // and the level switching from lvl_before to lvl_after at lvl_at.
  task automatic run_expect(input string tag, input int n, input logic [PW-1:0] pulse_mask,
                            input int pulse_at, input logic [PW-1:0] lvl_before,
                            input logic [PW-1:0] lvl_after, input int lvl_at,
                            output int pulses);
    logic [PW-1:0] exp_p, exp_l;
    pulses = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      exp_p = (i == pulse_at) ? pulse_mask : '0;
      exp_l = (i >= lvl_at) ? lvl_after : lvl_before;
      chk($sformatf("%s pulse c%0d", tag, i), 32'(o_pulsador), 32'(exp_p));
      chk($sformatf("%s level c%0d", tag, i), 32'(o_level), 32'(exp_l));
      if (o_pulsador[0]) pulses++;
    end
    $display("txn %s: %0d cycles, %0d pulses on ch0", tag, n, pulses);
  endtask

  initial begin
    int np;

    // Asynchronous reset with no clock edge involved
    #2 reset = 1'b0;
    #1;
    chk("rst pulse", 32'(o_pulsador), 32'd0);
    chk("rst level", 32'(o_level), 32'd0);
    tick(); tick();
    reset = 1'b1;
    run_expect("idle", 4, 3'b000, 0, 3'b000, 3'b000, 1, np);

    // Single press held 20 cycles, then release
    i_pulsador = 3'b001;
    run_expect("press0", 20, 3'b001, 6, 3'b000, 3'b001, 6, np);
    chk("press0 count", 32'(np), 32'd1);
    i_pulsador = 3'b000;
    run_expect("release0", 12, 3'b000, 0, 3'b001, 3'b000, 6, np);

    // Bouncing bit 1: 2 high, 1 low, never stable long enough
    for (int c = 0; c < 30; c++) begin
      i_pulsador = ((c % 3) < 2) ? 3'b010 : 3'b000;
      tick();
      chk($sformatf("glitch pulse c%0d", c), 32'(o_pulsador), 32'd0);
      chk($sformatf("glitch level c%0d", c), 32'(o_level), 32'd0);
    end
    $display("txn glitch: 30 cycles bouncing on ch1");
    i_pulsador = 3'b000;
    run_expect("glitch settle", 6, 3'b000, 0, 3'b000, 3'b000, 1, np);

    // Simultaneous presses on channels 0 and 2
    i_pulsador = 3'b101;
    run_expect("press02", 10, 3'b101, 6, 3'b000, 3'b101, 6, np);
    i_pulsador = 3'b000;
    run_expect("release02", 12, 3'b000, 0, 3'b101, 3'b000, 6, np);

    // Reset while HIGH clears the level without a clock edge
    i_pulsador = 3'b001;
    run_expect("press_hi", 8, 3'b001, 6, 3'b000, 3'b001, 6, np);
    #3 reset = 1'b0;
    #1;
    chk("async clr level", 32'(o_level), 32'd0);
    chk("async clr pulse", 32'(o_pulsador), 32'd0);
    $display("txn async_reset_high: level cleared mid-cycle");
    i_pulsador = 3'b000;
    tick(); tick(); tick();
    reset = 1'b1;
    run_expect("post_rst idle", 4, 3'b000, 0, 3'b000, 3'b000, 1, np);

    // Reset at cycle 3 of a press: partial count discarded, full sequence again
    i_pulsador = 3'b001;
    run_expect("press_rst pre", 3, 3'b000, 0, 3'b000, 3'b000, 1, np);
    reset = 1'b0;
    #1;
    chk("midpress rst pulse", 32'(o_pulsador), 32'd0);
    chk("midpress rst level", 32'(o_level), 32'd0);
    tick();
    reset = 1'b1;
    run_expect("press_rst post", 10, 3'b001, 6, 3'b000, 3'b001, 6, np);
    i_pulsador = 3'b000;
    run_expect("release_rst", 12, 3'b000, 0, 3'b001, 3'b000, 6, np);

    // Long hold: exactly one pulse
    i_pulsador = 3'b001;
    run_expect("hold100", 100, 3'b001, 6, 3'b000, 3'b001, 6, np);
    chk("hold100 count", 32'(np), 32'd1);
    i_pulsador = 3'b000;
    run_expect("release100", 12, 3'b000, 0, 3'b001, 3'b000, 6, np);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
